// File: rtl/sensor_hit_conditioner.sv
// Synchronises and debounces the sensor box code, emits one hit event per strike,
// scores it against the lit target and keeps a saturating matched-hit count.
module sensor_hit_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 12500000,
  parameter int CNT_W           = 24
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] gpio_in,
  input  logic [2:0] target_box,
  output logic       hit_valid,
  output logic [2:0] hit_box,
  output logic       hit_match,
  output logic       hit_miss,
  output logic [7:0] hit_count,
  output logic       sensor_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_REPORT,
    S_LOCKOUT,
    S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       code_s;
  state_t           state_q;
  logic [2:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit_valid_q;
  logic [2:0]       hit_box_q;
  logic             hit_match_q;
  logic             hit_miss_q;
  logic [7:0]       hit_count_q;
  logic             busy_q;
  logic             is_match;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 3'b000;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign code_s   = sync_q[SYNC_STAGES-1];
  assign cnt_d    = cnt_q + ONE_C;
  assign is_match = (cand_q == target_box) && (target_box != 3'b000);

  // The shared counter is compared on its incremented value so the REPORT
  // cycle lands exactly SYNC_STAGES + DEBOUNCE_CYCLES after the strike begins.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cand_q      <= 3'b000;
      cnt_q       <= '0;
      hit_valid_q <= 1'b0;
      hit_box_q   <= 3'b000;
      hit_match_q <= 1'b0;
      hit_miss_q  <= 1'b0;
      hit_count_q <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      hit_valid_q <= 1'b0;
      hit_match_q <= 1'b0;
      hit_miss_q  <= 1'b0;
      if (!enable) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (code_s != 3'b000) begin
              cand_q  <= code_s;
              cnt_q   <= ONE_C;
              state_q <= S_DEBOUNCE;
              busy_q  <= 1'b1;
            end
          end
          S_DEBOUNCE: begin
            if (code_s != cand_q) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else if (cnt_d >= DEB_C) begin
              state_q     <= S_REPORT;
              cnt_q       <= '0;
              hit_valid_q <= 1'b1;
              hit_box_q   <= cand_q;
              hit_match_q <= is_match;
              hit_miss_q  <= !is_match;
              if (is_match && (hit_count_q != 8'hFF)) begin
                hit_count_q <= hit_count_q + 8'd1;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_REPORT: begin
            state_q <= S_LOCKOUT;
            cnt_q   <= '0;
          end
          S_LOCKOUT: begin
            if (cnt_d >= LOCK_C) begin
              state_q <= S_RELEASE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_RELEASE: begin
            // A still-held press keeps resetting the count, so it never re-triggers.
            if (code_s != 3'b000) begin
              cnt_q <= '0;
            end else if (cnt_d >= DEB_C) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hit_valid   = hit_valid_q;
  assign hit_box     = hit_box_q;
  assign hit_match   = hit_match_q;
  assign hit_miss    = hit_miss_q;
  assign hit_count   = hit_count_q;
  assign sensor_busy = busy_q;

endmodule

// File: tb/tb_sensor_hit_conditioner.sv
// Directed bench for sensor_hit_conditioner with short debounce/lockout settings.
module tb_sensor_hit_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LOCK = 8;
  localparam int HIT_OFS = SYNC + DEB;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] gpio_in;
  logic [2:0] target_box;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic       hit_match;
  logic       hit_miss;
  logic [7:0] hit_count;
  logic       sensor_busy;

  int errors = 0;
  int checks = 0;

  sensor_hit_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES(LOCK),
    .CNT_W(24)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .enable(enable),
    .gpio_in(gpio_in),
    .target_box(target_box),
    .hit_valid(hit_valid),
    .hit_box(hit_box),
    .hit_match(hit_match),
    .hit_miss(hit_miss),
    .hit_count(hit_count),
    .sensor_busy(sensor_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    bit en;
    int tgt0;        // target for offsets 0..2
    int tgt1;        // target from offset 3 on (mid-debounce change)
    int code;
    int hold;
    int exp_pulses;
    int exp_box;
    int exp_match;
    int exp_count;
    int exp_busy;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {18'd0, hit_valid, hit_match, hit_miss, hit_box, hit_count, sensor_busy};
  endfunction

  // Drives one strike window and scores the single event it must (or must not) produce.
  task automatic run_vec(input vec_t v);
    int pulses = 0;
    int poff = -1;
    int pbox = 0;
    int pm = 0;
    int pmiss = 0;
    int both = 0;
    int busy_seen = 0;
    for (int c = 0; c < v.hold + 24; c++) begin
      enable     = v.en;
      target_box = (c < 3) ? 3'(v.tgt0) : 3'(v.tgt1);
      gpio_in    = (c < v.hold) ? 3'(v.code) : 3'b000;
      if (hit_valid) begin
        pulses++;
        if (pulses == 1) begin
          poff  = c;
          pbox  = int'(hit_box);
          pm    = int'(hit_match);
          pmiss = int'(hit_miss);
        end
      end
      if (hit_match && hit_miss) both = 1;
      if (sensor_busy) busy_seen = 1;
      tick();
    end
    chk("pulse_count", pulses, v.exp_pulses);
    if (v.exp_pulses == 1) begin
      chk("pulse_latency", poff, HIT_OFS);
      chk("pulse_box", pbox, v.exp_box);
      chk("pulse_match", pm, v.exp_match);
      chk("pulse_miss", pmiss, (v.exp_match == 0) ? 1 : 0);
    end
    chk("box_held", hit_box, v.exp_box);
    chk("hit_count", hit_count, v.exp_count);
    chk("busy_end", sensor_busy, 0);
    chk("busy_seen", busy_seen, v.exp_busy);
    chk("match_miss_excl", both, 0);
  endtask

  vec_t tbl[10];

  initial begin
    int pulses;
    vec_t v;

    tbl[0] = '{1'b1, 5, 5, 5, 6,  1, 5, 1, 1, 1};  // matched strike
    tbl[1] = '{1'b1, 5, 5, 3, 3,  0, 5, 0, 1, 1};  // too short to debounce
    tbl[2] = '{1'b1, 4, 4, 2, 6,  1, 2, 0, 1, 1};  // wrong box
    tbl[3] = '{1'b1, 0, 0, 1, 6,  1, 1, 0, 1, 1};  // no target lit
    tbl[4] = '{1'b1, 5, 5, 5, 60, 1, 5, 1, 2, 1};  // long hold, single event
    tbl[5] = '{1'b1, 5, 5, 5, 6,  1, 5, 1, 3, 1};  // fresh press after release
    tbl[6] = '{1'b0, 5, 5, 5, 6,  0, 5, 0, 3, 0};  // disabled
    tbl[7] = '{1'b1, 3, 3, 3, 1,  0, 5, 0, 3, 1};  // one-cycle glitch
    tbl[8] = '{1'b1, 1, 4, 4, 6,  1, 4, 1, 4, 1};  // target changes mid-debounce
    tbl[9] = '{1'b1, 6, 6, 6, 6,  1, 6, 1, 5, 1};

    reset = 1'b1;
    enable = 1'b0;
    gpio_in = 3'b000;
    target_box = 3'b000;
    #1;
    chk("reset_t0", outs_vec(), 0);
    tick();
    tick();
    chk("reset_held", outs_vec(), 0);
    tick();
    reset = 1'b0;
    enable = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      chk("idle_after_reset", outs_vec(), 0);
      tick();
    end

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i]);
    end

    // enable dropped at offset 4, while still debouncing
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      enable = (c < 4) ? 1'b1 : 1'b0;
      target_box = 3'd6;
      gpio_in = (c < 6) ? 3'd6 : 3'd0;
      if (c == 5) chk("en_drop_idle", sensor_busy, 0);
      if (hit_valid) pulses++;
      tick();
    end
    chk("en_drop_no_pulse", pulses, 0);
    chk("en_drop_count", hit_count, 5);

    // enable low only on the cycle that would enter REPORT
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      enable = (c == 5) ? 1'b0 : 1'b1;
      target_box = 3'd6;
      gpio_in = (c < 4) ? 3'd6 : 3'd0;
      if (hit_valid) pulses++;
      tick();
    end
    chk("en_report_no_pulse", pulses, 0);
    chk("en_report_count", hit_count, 5);
    chk("en_report_box", hit_box, 6);

    // async reset during lockout
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      enable = 1'b1;
      target_box = 3'd7;
      gpio_in = (c < 6) ? 3'd7 : 3'd0;
      if (hit_valid) pulses++;
      tick();
    end
    chk("pre_reset_pulse", pulses, 1);
    chk("pre_reset_count", hit_count, 6);
    chk("pre_reset_busy", sensor_busy, 1);
    reset = 1'b1;
    #1;
    chk("reset_lockout", outs_vec(), 0);
    tick();
    reset = 1'b0;
    tick();
    v = '{1'b1, 7, 7, 7, 6, 1, 7, 1, 1, 1};
    run_vec(v);

    // saturation: fill to 255 then one more match
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("sat_start", hit_count, 0);
    for (int i = 0; i < 255; i++) begin
      v = '{1'b1, 2, 2, 2, 6, 1, 2, 1, i + 1, 1};
      run_vec(v);
    end
    chk("sat_full", hit_count, 255);
    v = '{1'b1, 2, 2, 2, 6, 1, 2, 1, 255, 1};
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_hit_conditioner.md
Name: sensor_hit_conditioner

Overview:
Conditions the raw 3-bit box code from the Arduino sensor GPIO before the game datapath uses it. It synchronises and debounces the code, then issues exactly one hit event per physical strike. Each event is compared against the currently displayed target box, and a saturating hit counter is kept. It sits directly upstream of the game datapath, which consumes hit_valid/hit_match instead of comparing raw GPIO levels every cycle.

Parameters:
SYNC_STAGES, 2, flip-flop stages per gpio bit (min 2)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz; min 1)
LOCKOUT_CYCLES, 12500000, cycles input is ignored after a reported hit (250 ms; min 1)
CNT_W, 24, width of the shared debounce/lockout counter; must hold max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  game active; low forces IDLE and suppresses events
gpio_in  in  3  raw box code from sensor; 3'b000 = no strike
target_box  in  3  box currently lit; 3'b000 = no target
hit_valid  out  1  one-cycle pulse, a debounced strike was accepted
hit_box  out  3  box code of the accepted strike, held until the next event
hit_match  out  1  high with hit_valid when hit_box == target_box and target_box != 0
hit_miss  out  1  high with hit_valid when hit_match is not true
hit_count  out  8  count of matched hits, saturates at 255
sensor_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async): all sync flops 0; state IDLE; counter 0; hit_valid, hit_box, hit_match, hit_miss, hit_count and sensor_busy all 0.
- Synchroniser output code_s equals gpio_in delayed SYNC_STAGES cycles. All decisions use code_s only.
- FSM states: IDLE, DEBOUNCE, REPORT, LOCKOUT, RELEASE.
- IDLE: if enable and code_s != 0, capture cand <= code_s, load counter with 1, go to DEBOUNCE.
- DEBOUNCE: if code_s != cand (including 0), go to IDLE with no event. Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES, go to REPORT.
- REPORT: lasts exactly one cycle.
  - hit_valid = 1; hit_box = cand.
  - hit_match = (cand == target_box), using target_box sampled on the cycle that enters REPORT; hit_miss = !hit_match.
  - If matched, hit_count += 1, saturating at 255.
  - Next state is LOCKOUT with counter cleared.
- LOCKOUT: input is ignored; counter increments. When the counter reaches LOCKOUT_CYCLES, go to RELEASE with counter cleared.
- RELEASE: counts consecutive cycles with code_s == 0; any nonzero code_s clears the count. After DEBOUNCE_CYCLES zero cycles, go to IDLE. A held press therefore never re-triggers.
- Latency: if gpio_in first holds value v != 0 at cycle t0 and stays constant, hit_valid is high in cycle t0 + SYNC_STAGES + DEBOUNCE_CYCLES.
- hit_valid, hit_match and hit_miss are registered. Outside REPORT they are 0. hit_match and hit_miss are never both high.
- enable low in any state: next state is IDLE, counter cleared, no event. If enable is low on the cycle DEBOUNCE would enter REPORT, no pulse occurs. hit_count and hit_box are retained.
- target_box == 0: every event reports hit_miss.
- A change of target_box during DEBOUNCE or LOCKOUT is legal. Only the value at REPORT entry matters.
- Reset mid-operation (any state): immediate return to reset values, including hit_count = 0.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8):
1. Assert reset at cycle 0, release at cycle 3 -> all outputs 0, sensor_busy 0 through cycle 10 with gpio_in = 0.
2. enable=1, target_box=5, gpio_in=3'b101 from cycle 10, held 6 cycles then 0 -> single hit_valid at cycle 16, hit_box=5, hit_match=1, hit_miss=0, hit_count=1.
3. gpio_in=3'b011 for 3 cycles, then 0 -> no hit_valid; sensor_busy pulses, then returns to 0; hit_count unchanged.
4. target_box=4, gpio_in=3'b010 held 6 cycles -> hit_valid with hit_box=2, hit_miss=1, hit_match=0, hit_count unchanged. Repeat with target_box=0 and gpio=3'b000→3'b001 -> hit_miss=1.
5. gpio_in=3'b101 held 60 cycles -> exactly one pulse. Release to 0 for ≥4 cycles, press again -> second pulse. Preload 255 matched hits -> hit_count stays 255 on the next match.
6. Drop enable during DEBOUNCE (cycle t0+4) -> no pulse, state IDLE. Assert reset during LOCKOUT -> outputs 0, hit_count 0, next press is debounced normally.
